// File: rtl/tabla_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tabla_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } tabla_state_e;

  // Width of the per-row settle down-counter.
  localparam int TIMER_W = 4;

  // Legal parameter ranges.
  localparam int N_IN_MIN   = 2;
  localparam int N_IN_MAX   = 6;
  localparam int SETTLE_MIN = 0;
  localparam int SETTLE_MAX = 15;

  // Number of truth-table rows for a given input count.
  function automatic int rows_of(input int n_in);
    return 32'sd1 << n_in;
  endfunction

  // True when the input count is within the supported range.
  function automatic bit n_in_legal(input int n_in);
    return (n_in >= N_IN_MIN) && (n_in <= N_IN_MAX);
  endfunction

  // True when the settle time fits the counter.
  function automatic bit settle_legal(input int settle);
    return (settle >= SETTLE_MIN) && (settle <= SETTLE_MAX);
  endfunction

  // The counter holds the number of SETTLE cycles still to spend after the
  // current one, so a row with SETTLE extra cycles loads SETTLE-1.
  function automatic logic [TIMER_W-1:0] settle_reload(input int settle);
    if (settle > 0) begin
      return TIMER_W'(settle - 1);
    end else begin
      return {TIMER_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/tabla_settle_timer.sv
// Loadable 4-bit down-counter with zero flag used to time the settle window.
module tabla_settle_timer
  import tabla_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               zero_o
);

  logic [TIMER_W-1:0] cnt_q;
  logic [TIMER_W-1:0] cnt_d;

  // Next count: load has priority, decrement stops at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != {TIMER_W{1'b0}})) begin
      cnt_d = cnt_q - TIMER_W'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= {TIMER_W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == {TIMER_W{1'b0}});

endmodule

// File: rtl/tabla_sweeper.sv
// Exhaustive truth-table sweeper: drives every input row onto a function
// under test, samples its output after a settle window and compares the
// captured minterm vector against an expected mask.
module tabla_sweeper
  import tabla_pkg::*;
#(
  parameter int N_IN   = 4,
  parameter int SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [(1<<N_IN)-1:0]   expected,
  output logic [N_IN-1:0]        vec,
  input  logic                   y,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   result,
  output logic [N_IN:0]          mismatches,
  output logic [N_IN-1:0]        first_fail,
  output logic                   fail_valid
);

  localparam int                 ROWS          = 1 << N_IN;
  localparam logic [N_IN:0]      LAST_ROW      = (N_IN+1)'(ROWS - 1);
  localparam logic [TIMER_W-1:0] SETTLE_RELOAD = settle_reload(SETTLE);

  if (!n_in_legal(N_IN) || !settle_legal(SETTLE)) begin : g_param_check
    $fatal(1, "tabla_sweeper: N_IN must be 2..6 and SETTLE 0..15");
  end

  tabla_state_e        state_q, state_d;
  logic [N_IN:0]       row_q, row_d;
  logic [ROWS-1:0]     exp_q, exp_d;
  logic [ROWS-1:0]     result_q, result_d;
  logic [N_IN:0]       mism_q, mism_d;
  logic [N_IN-1:0]     ff_q, ff_d;
  logic                fv_q, fv_d;
  logic                pass_q, pass_d;
  logic [N_IN-1:0]     vec_q, vec_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tmr_load;
  logic                tmr_dec;
  logic                tmr_zero;
  logic [N_IN-1:0]     row_idx;

  assign row_idx = row_q[N_IN-1:0];

  tabla_settle_timer u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (tmr_load),
    .load_val_i (SETTLE_RELOAD),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // Next-state, row stepping and capture/compare logic.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    exp_d    = exp_q;
    result_d = result_q;
    mism_d   = mism_q;
    ff_d     = ff_q;
    fv_d     = fv_q;
    pass_d   = pass_q;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // Abort has no effect here, so a simultaneous start still launches.
        if (start) begin
          exp_d    = expected;
          result_d = {ROWS{1'b0}};
          mism_d   = {(N_IN+1){1'b0}};
          ff_d     = {N_IN{1'b0}};
          fv_d     = 1'b0;
          pass_d   = 1'b0;
          row_d    = {(N_IN+1){1'b0}};
          if (SETTLE == 0) begin
            state_d = ST_SAMPLE;
          end else begin
            state_d  = ST_SETTLE;
            tmr_load = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          state_d = ST_IDLE;
          row_d   = {(N_IN+1){1'b0}};
          pass_d  = 1'b0;
        end else if (tmr_zero) begin
          state_d = ST_SAMPLE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (abort) begin
          // Cancel wins over the capture scheduled for this edge.
          state_d = ST_IDLE;
          row_d   = {(N_IN+1){1'b0}};
          pass_d  = 1'b0;
        end else begin
          result_d[row_idx] = y;
          if (y != exp_q[row_idx]) begin
            mism_d = mism_q + (N_IN+1)'(1);
            if (!fv_q) begin
              ff_d = row_idx;
              fv_d = 1'b1;
            end else begin
              ff_d = ff_q;
            end
          end else begin
            mism_d = mism_q;
          end
          if (row_q == LAST_ROW) begin
            state_d = ST_DONE;
            pass_d  = (mism_d == {(N_IN+1){1'b0}});
          end else begin
            row_d = row_q + (N_IN+1)'(1);
            if (SETTLE == 0) begin
              state_d = ST_SAMPLE;
            end else begin
              state_d  = ST_SETTLE;
              tmr_load = 1'b1;
            end
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next values derived from the next state so outputs are registered.
  always_comb begin
    busy_d = (state_d == ST_SETTLE) || (state_d == ST_SAMPLE);
    done_d = (state_d == ST_DONE);
    if (busy_d) begin
      vec_d = row_d[N_IN-1:0];
    end else begin
      vec_d = {N_IN{1'b0}};
    end
  end

  // FSM, row counter and capture/compare registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      row_q    <= {(N_IN+1){1'b0}};
      exp_q    <= {ROWS{1'b0}};
      result_q <= {ROWS{1'b0}};
      mism_q   <= {(N_IN+1){1'b0}};
      ff_q     <= {N_IN{1'b0}};
      fv_q     <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      exp_q    <= exp_d;
      result_q <= result_d;
      mism_q   <= mism_d;
      ff_q     <= ff_d;
      fv_q     <= fv_d;
      pass_q   <= pass_d;
    end
  end

  // Registered handshake and stimulus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q  <= {N_IN{1'b0}};
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      vec_q  <= vec_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  assign vec        = vec_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign result     = result_q;
  assign mismatches = mism_q;
  assign first_fail = ff_q;
  assign fail_valid = fv_q;

endmodule

// File: tb/tb_tabla_sweeper.sv
// Self-checking bench: two sweepers (3 inputs/settle 1 and 4 inputs/settle 0)
// driving table-defined functions, checked against a truth-table model.
module tb_tabla_sweeper;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        start_a = 1'b0, abort_a = 1'b0;
  logic [7:0]  exp_a = 8'h00, tbl_a = 8'h00;
  logic [2:0]  vec_a;
  logic        y_a, busy_a, done_a, pass_a, fv_a;
  logic [7:0]  res_a;
  logic [3:0]  mm_a;
  logic [2:0]  ff_a;

  logic        start_b = 1'b0, abort_b = 1'b0;
  logic [15:0] exp_b = 16'h0000, tbl_b = 16'h0000;
  logic [3:0]  vec_b;
  logic        y_b, busy_b, done_b, pass_b, fv_b;
  logic [15:0] res_b;
  logic [4:0]  mm_b;
  logic [3:0]  ff_b;

  int checks = 0;
  int errors = 0;
  bit sel = 1'b0;

  // Function under test: output read straight from a truth table.
  assign y_a = tbl_a[vec_a];
  assign y_b = tbl_b[vec_b];

  tabla_sweeper #(.N_IN(3), .SETTLE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
    .expected(exp_a), .vec(vec_a), .y(y_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .result(res_a), .mismatches(mm_a), .first_fail(ff_a),
    .fail_valid(fv_a)
  );

  tabla_sweeper #(.N_IN(4), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
    .expected(exp_b), .vec(vec_b), .y(y_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .result(res_b), .mismatches(mm_b), .first_fail(ff_b),
    .fail_valid(fv_b)
  );

  always #5 clk = ~clk;

  logic [15:0] res_s;
  logic [4:0]  mm_s;
  logic [3:0]  ff_s, vec_s;
  logic        busy_s, done_s, pass_s, fv_s;
  assign res_s  = sel ? res_b  : {8'h00, res_a};
  assign mm_s   = sel ? mm_b   : {1'b0, mm_a};
  assign ff_s   = sel ? ff_b   : {1'b0, ff_a};
  assign vec_s  = sel ? vec_b  : {1'b0, vec_a};
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign pass_s = sel ? pass_b : pass_a;
  assign fv_s   = sel ? fv_b   : fv_a;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endtask

  // Reference: the captured table is the function's table; the verdict
  // follows from the rows where it disagrees with the expected mask.
  function automatic void model(input bit d, input logic [15:0] tb, input logic [15:0] ex,
                                output logic [15:0] r, output int mm, output int ff,
                                output logic fv, output logic p);
    logic [15:0] mask, diff;
    mask = d ? 16'hFFFF : 16'h00FF;
    r    = tb & mask;
    diff = (tb ^ ex) & mask;
    mm   = $countones(diff);
    fv   = |diff;
    p    = ~fv;
    ff   = 0;
    for (int i = 15; i >= 0; i--) if (diff[i]) ff = i;
  endfunction

  // One sweep from IDLE; poke adds a start during busy and in the done
  // cycle, and an abort together with the launching start.
  task automatic sweep(input bit d, input logic [15:0] tb, input logic [15:0] ex,
                       input bit poke, output int bc, output int dc, output logic pd);
    sel = d;
    if (!d) begin tbl_a = tb[7:0]; exp_a = ex[7:0]; start_a = 1'b1; abort_a = poke; end
    else    begin tbl_b = tb;      exp_b = ex;      start_b = 1'b1; abort_b = poke; end
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0; abort_a = 1'b0; abort_b = 1'b0;
    bc = 0; dc = 0; pd = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (busy_s) bc++;
      if (done_s) begin
        dc++;
        pd = pass_s;
        if (poke) begin start_a = !d; start_b = d; end
      end else if (poke && c == 5) begin
        start_a = !d; start_b = d;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      @(negedge clk);
    end
    start_a = 1'b0; start_b = 1'b0;
  endtask

  task automatic check_sweep(input string tag, input bit d, input logic [15:0] tb,
                             input logic [15:0] ex, input bit poke);
    int bc, dc, mm, ff;
    logic pd, fv, p;
    logic [15:0] r;
    model(d, tb, ex, r, mm, ff, fv, p);
    sweep(d, tb, ex, poke, bc, dc, pd);
    chk({tag, " busy_cycles"}, bc, 16);
    chk({tag, " done_pulses"}, dc, 1);
    chk({tag, " pass_at_done"}, pd, p);
    chk({tag, " pass"}, pass_s, p);
    chk({tag, " result"}, res_s, r);
    chk({tag, " mismatches"}, mm_s, mm);
    chk({tag, " first_fail"}, ff_s, ff);
    chk({tag, " fail_valid"}, fv_s, fv);
  endtask

  typedef struct {
    bit          d;
    logic [15:0] tb;
    logic [15:0] ex;
    logic [15:0] r;
    int          mm;
    int          ff;
    logic        fv;
    logic        p;
  } vec_t;

  vec_t vt[8];

  initial begin
    int bc, dc, found;
    logic pd;
    logic [15:0] tb, ex;

    // Hand-derived cases: majority, xor of A and D, boundary rows and counts.
    vt[0] = '{1'b0, 16'h00E8, 16'h00E8, 16'h00E8, 0, 0, 1'b0, 1'b1};
    vt[1] = '{1'b0, 16'h00E8, 16'h00C8, 16'h00E8, 1, 5, 1'b1, 1'b0};
    vt[2] = '{1'b1, 16'h55AA, 16'h55AA, 16'h55AA, 0, 0, 1'b0, 1'b1};
    vt[3] = '{1'b1, 16'h55AA, 16'hFFFF, 16'h55AA, 8, 0, 1'b1, 1'b0};
    vt[4] = '{1'b0, 16'h0000, 16'h00FF, 16'h0000, 8, 0, 1'b1, 1'b0};
    vt[5] = '{1'b1, 16'h8000, 16'h0000, 16'h8000, 1, 15, 1'b1, 1'b0};
    vt[6] = '{1'b0, 16'h0080, 16'h0000, 16'h0080, 1, 7, 1'b1, 1'b0};
    vt[7] = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16, 0, 1'b1, 1'b0};

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst busy_a", busy_a, 0);
    chk("rst vec_a", vec_a, 0);
    chk("rst done_b", done_b, 0);
    chk("rst pass_b", pass_b, 0);
    chk("rst result_b", res_b, 0);
    chk("rst mism_b", mm_b, 0);
    chk("rst fv_a", fv_a, 0);

    for (int i = 0; i < 8; i++) begin
      sweep(vt[i].d, vt[i].tb, vt[i].ex, i[0], bc, dc, pd);
      chk($sformatf("vt%0d busy_cycles", i), bc, 16);
      chk($sformatf("vt%0d done_pulses", i), dc, 1);
      chk($sformatf("vt%0d pass_at_done", i), pd, vt[i].p);
      chk($sformatf("vt%0d result", i), res_s, vt[i].r);
      chk($sformatf("vt%0d mismatches", i), mm_s, vt[i].mm);
      chk($sformatf("vt%0d first_fail", i), ff_s, vt[i].ff);
      chk($sformatf("vt%0d fail_valid", i), fv_s, vt[i].fv);
    end

    // Abort while vec=3 on the 3-input sweeper, all-ones function.
    sel = 1'b0;
    tbl_a = 8'hFF; exp_a = 8'hE8; start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      if (vec_a == 3'd3) found = 1;
      else @(negedge clk);
    end
    chk("abort reach_vec3", found, 1);
    abort_a = 1'b1;
    @(negedge clk);
    abort_a = 1'b0;
    chk("abort busy", busy_a, 0);
    chk("abort vec", vec_a, 0);
    dc = 0;
    for (int c = 0; c < 12; c++) begin
      if (done_a) dc++;
      @(negedge clk);
    end
    chk("abort done_pulses", dc, 0);
    chk("abort pass", pass_a, 0);
    chk("abort partial_result", res_a, 8'h07);
    chk("abort partial_mism", mm_a, 3);
    chk("abort fail_valid", fv_a, 1);
    check_sweep("after_abort", 1'b0, 16'h00E8, 16'h00E8, 1'b0);

    // Asynchronous reset in the middle of a 4-input sweep.
    sel = 1'b1;
    tbl_b = 16'h55AA; exp_b = 16'h0000; start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_rst busy", busy_b, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst busy", busy_b, 0);
    chk("midrst vec", vec_b, 0);
    chk("midrst result", res_b, 0);
    chk("midrst mism", mm_b, 0);
    chk("midrst fv", fv_b, 0);
    chk("midrst ff", ff_b, 0);
    chk("midrst pass", pass_b, 0);
    chk("midrst done", done_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst busy", busy_b, 0);
    check_sweep("after_rst", 1'b1, 16'h55AA, 16'h55AA, 1'b1);

    // Randomized sweeps against the model.
    for (int i = 0; i < 16; i++) begin
      tb = 16'($urandom);
      case ($urandom_range(0, 2))
        0:       ex = tb;
        1:       ex = tb ^ (16'h0001 << $urandom_range(0, 15));
        default: ex = 16'($urandom);
      endcase
      check_sweep($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), tb, ex,
                  1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
